// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: iterative AES encryption round sequencer.
// Does the initial AddRoundKey, then NR rounds of SubBytes/ShiftRows,
// MixColumns (skipped in the last round) and AddRoundKey, using external
// units through en/done pulse handshakes.
// Ports: clk_i/rst_n (async active-low); in_* plaintext valid/ready;
// out_* ciphertext valid/ready; rk_idx_o/rk_i round-key lookup (same
// cycle); ss_* SubBytes/ShiftRows unit; mc_* MixColumn unit; busy_o.
// Optional macro AES_ABORT_EN adds abort_i (forces IDLE from any state).
module aes_round_ctrl #(
    parameter int NR       = 10,
    parameter int RK_IDX_W = 4
) (
    input  logic                clk_i,
    input  logic                rst_n,
`ifdef AES_ABORT_EN
    input  logic                abort_i,
`endif
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [127:0]        in_data_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [127:0]        out_data_o,
    output logic [RK_IDX_W-1:0] rk_idx_o,
    input  logic [127:0]        rk_i,
    output logic                ss_en_o,
    output logic [127:0]        ss_state_o,
    input  logic [127:0]        ss_state_i,
    input  logic                ss_done_i,
    output logic                mc_en_o,
    output logic [127:0]        mc_state_o,
    input  logic [127:0]        mc_state_i,
    input  logic                mc_done_i,
    output logic                busy_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SUB,
        S_SUB_WAIT,
        S_MIX,
        S_MIX_WAIT,
        S_ARK,
        S_OUT
    } state_e;

    localparam logic [RK_IDX_W-1:0] LAST = RK_IDX_W'(NR);

    state_e                state_q, state_d;
    logic [RK_IDX_W-1:0]   round_q, round_d;
    logic [RK_IDX_W-1:0]   rk_idx_q, rk_idx_d;
    logic [127:0]          data_q, data_d;
    logic                  in_ready_q, in_ready_d;
    logic                  out_valid_q, out_valid_d;
    logic                  ss_en_q, ss_en_d;
    logic                  mc_en_q, mc_en_d;
    logic                  busy_q, busy_d;

    always_comb begin
        state_d = state_q;
        round_d = round_q;
        data_d  = data_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid_i) begin
                    data_d  = in_data_i ^ rk_i;
                    round_d = RK_IDX_W'(1);
                    state_d = S_SUB;
                end
            end
            S_SUB: state_d = S_SUB_WAIT;
            S_SUB_WAIT: begin
                if (ss_done_i) begin
                    data_d  = ss_state_i;
                    state_d = (round_q == LAST) ? S_ARK : S_MIX;
                end
            end
            S_MIX: state_d = S_MIX_WAIT;
            S_MIX_WAIT: begin
                if (mc_done_i) begin
                    data_d  = mc_state_i;
                    state_d = S_ARK;
                end
            end
            S_ARK: begin
                data_d = data_q ^ rk_i;
                if (round_q == LAST) begin
                    state_d = S_OUT;
                end else begin
                    round_d = round_q + 1'b1;
                    state_d = S_SUB;
                end
            end
            S_OUT: begin
                if (out_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
`ifdef AES_ABORT_EN
        if (abort_i && state_q != S_IDLE) begin
            state_d = S_IDLE;
            round_d = '0;
            data_d  = data_q;
        end
`endif
        // Outputs are registered: decode them from the next state so they
        // line up with the state they belong to.
        in_ready_d  = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
        ss_en_d     = (state_d == S_SUB);
        mc_en_d     = (state_d == S_MIX);
        out_valid_d = (state_d == S_OUT);
        rk_idx_d    = (state_d == S_ARK) ? round_d : '0;
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            round_q     <= '0;
            data_q      <= '0;
            rk_idx_q    <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            ss_en_q     <= 1'b0;
            mc_en_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            round_q     <= round_d;
            data_q      <= data_d;
            rk_idx_q    <= rk_idx_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            ss_en_q     <= ss_en_d;
            mc_en_q     <= mc_en_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign ss_en_o     = ss_en_q;
    assign mc_en_o     = mc_en_q;
    assign busy_o      = busy_q;
    assign rk_idx_o    = rk_idx_q;
    assign out_data_o  = data_q;
    assign ss_state_o  = data_q;
    assign mc_state_o  = data_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb_aes_round_ctrl: bench for aes_round_ctrl with a behavioural AES
// model (S-box, ShiftRows, MixColumns, key expansion) and unit models.
module tb_aes_round_ctrl;

    typedef logic [127:0] rk_arr_t [16];
    typedef struct {
        logic [127:0] pt;
        logic [127:0] key;
        logic [127:0] ct;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [127:0] in_data = '0;
`ifdef AES_ABORT_EN
    logic         abort = 1'b0;
`endif

    logic         in_ready_A, out_valid_A, ss_en_A, mc_en_A, busy_A;
    logic [127:0] out_data_A, ss_st_A, mc_st_A, rk_A;
    logic [127:0] ss_in_A, mc_in_A;
    logic [3:0]   rk_idx_A;
    logic         ssA_done = 1'b0, mcA_done = 1'b0, spur_mc = 1'b0;
    logic [127:0] ssA_res = '0, mcA_res = '0;

    logic         in_valid_B = 1'b0, out_ready_B = 1'b0;
    logic         in_ready_B, out_valid_B, ss_en_B, mc_en_B, busy_B;
    logic [127:0] out_data_B, ss_st_B, mc_st_B, rk_B;
    logic [127:0] ss_in_B, mc_in_B;
    logic [3:0]   rk_idx_B;
    logic         ssB_done = 1'b0, mcB_done = 1'b0;
    logic [127:0] ssB_res = '0, mcB_res = '0;

    logic [127:0] noise = '0;
    logic [7:0]   sb [256];
    rk_arr_t      rkA, rkB;
    int           ss_dly = 1, mc_dly = 1, ssA_c = 0, mcA_c = 0;
    int           ssA_p = 0, mcA_p = 0, ssB_p = 0, mcB_p = 0;
    bit           spur_en = 1'b0, ss_seen = 1'b0;
    int           n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    aes_round_ctrl #(.NR(10), .RK_IDX_W(4)) dut_a (
        .clk_i(clk), .rst_n(rst_n),
`ifdef AES_ABORT_EN
        .abort_i(abort),
`endif
        .in_valid_i(in_valid), .in_ready_o(in_ready_A),
        .in_data_i(in_data), .out_valid_o(out_valid_A),
        .out_ready_i(out_ready), .out_data_o(out_data_A),
        .rk_idx_o(rk_idx_A), .rk_i(rk_A),
        .ss_en_o(ss_en_A), .ss_state_o(ss_st_A),
        .ss_state_i(ss_in_A), .ss_done_i(ssA_done),
        .mc_en_o(mc_en_A), .mc_state_o(mc_st_A),
        .mc_state_i(mc_in_A), .mc_done_i(mcA_done | spur_mc),
        .busy_o(busy_A)
    );

    aes_round_ctrl #(.NR(14), .RK_IDX_W(4)) dut_b (
        .clk_i(clk), .rst_n(rst_n),
`ifdef AES_ABORT_EN
        .abort_i(1'b0),
`endif
        .in_valid_i(in_valid_B), .in_ready_o(in_ready_B),
        .in_data_i(in_data), .out_valid_o(out_valid_B),
        .out_ready_i(out_ready_B), .out_data_o(out_data_B),
        .rk_idx_o(rk_idx_B), .rk_i(rk_B),
        .ss_en_o(ss_en_B), .ss_state_o(ss_st_B),
        .ss_state_i(ss_in_B), .ss_done_i(ssB_done),
        .mc_en_o(mc_en_B), .mc_state_o(mc_st_B),
        .mc_state_i(mc_in_B), .mc_done_i(mcB_done),
        .busy_o(busy_B)
    );

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] gb(input logic [127:0] s, input int r, input int c);
        return s[127 - 8 * (4 * c + r) -: 8];
    endfunction

    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127 - 8 * (4 * c + r) -: 8] = sb[gb(s, r, (c + r) % 4)];
        return o;
    endfunction

    function automatic logic [127:0] mix(input logic [127:0] s);
        logic [127:0] o = '0;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = gb(s, 0, c); a1 = gb(s, 1, c);
            a2 = gb(s, 2, c); a3 = gb(s, 3, c);
            o[127 - 32 * c -: 32] = {
                xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
        end
        return o;
    endfunction

    function automatic logic [127:0] encrypt(input logic [127:0] pt,
                                             input int nr, input rk_arr_t k);
        logic [127:0] s = pt ^ k[0];
        for (int r = 1; r <= nr; r++) begin
            s = sub_shift(s);
            if (r < nr) s = mix(s);
            s = s ^ k[r];
        end
        return s;
    endfunction

    task automatic expand128(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
                t = t ^ {rcon, 24'h0};
                rcon = xt(rcon);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int i = 0; i < 16; i++)
            rkA[i] = (i < 11) ? {w[4*i], w[4*i+1], w[4*i+2], w[4*i+3]} : '0;
    endtask

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    assign rk_A    = rkA[rk_idx_A];
    assign rk_B    = rkB[rk_idx_B];
    assign ss_in_A = ssA_done ? ssA_res : noise;
    assign mc_in_A = mcA_done ? mcA_res : noise;
    assign ss_in_B = ssB_done ? ssB_res : noise;
    assign mc_in_B = mcB_done ? mcB_res : noise;

    always @(posedge clk) begin
        noise <= {$urandom, $urandom, $urandom, $urandom};
        if (ss_en_A) ssA_p <= ssA_p + 1;
        if (mc_en_A) mcA_p <= mcA_p + 1;
        if (ss_en_B) ssB_p <= ssB_p + 1;
        if (mc_en_B) mcB_p <= mcB_p + 1;
        ssA_done <= 1'b0;
        if (ss_en_A) begin
            ssA_res <= sub_shift(ss_st_A);
            if (ss_dly <= 1) ssA_done <= 1'b1;
            else ssA_c <= ss_dly - 1;
        end else if (ssA_c > 0) begin
            ssA_c <= ssA_c - 1;
            if (ssA_c == 1) ssA_done <= 1'b1;
        end
        mcA_done <= 1'b0;
        if (mc_en_A) begin
            mcA_res <= mix(mc_st_A);
            if (mc_dly <= 1) mcA_done <= 1'b1;
            else mcA_c <= mc_dly - 1;
        end else if (mcA_c > 0) begin
            mcA_c <= mcA_c - 1;
            if (mcA_c == 1) mcA_done <= 1'b1;
        end
        ssB_done <= ss_en_B;
        mcB_done <= mc_en_B;
        if (ss_en_B) ssB_res <= sub_shift(ss_st_B);
        if (mc_en_B) mcB_res <= mix(mc_st_B);
    end

    // Spurious MixColumn done, one cycle after the SubBytes start pulse.
    always @(negedge clk) begin
        ss_seen <= ss_en_A;
        spur_mc <= spur_en && ss_seen;
    end

    task automatic run_a(input logic [127:0] pt, input logic [127:0] exp,
                         input int hold, input bit chk_lat, input string nm);
        int t = 0;
        int b_ss, b_mc;
        logic [127:0] snap;
        bit ok = 1'b1;
        while (!in_ready_A && t < 200) begin @(negedge clk); t++; end
        in_data = pt; in_valid = 1'b1;
        b_ss = ssA_p; b_mc = mcA_p;
        @(negedge clk);
        in_valid = 1'b0;
        t = 1;
        while (!out_valid_A && t < 3000) begin @(negedge clk); t++; end
        chk({nm, " valid"}, out_valid_A, 1'b1);
        chk({nm, " ct"}, out_data_A, exp);
        chk({nm, " taps"}, {ss_st_A == out_data_A, mc_st_A == out_data_A}, 2'b11);
        if (chk_lat) chk({nm, " latency"}, t, 49);
        chk({nm, " ss pulses"}, ssA_p - b_ss, 10);
        chk({nm, " mc pulses"}, mcA_p - b_mc, 9);
        if (hold > 0) begin
            snap = out_data_A;
            repeat (hold) begin
                @(negedge clk);
                if (!out_valid_A || in_ready_A || out_data_A !== snap) ok = 1'b0;
            end
            chk({nm, " backpressure"}, ok, 1'b1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({nm, " idle"}, {out_valid_A, in_ready_A, busy_A}, 3'b010);
    endtask

    initial begin
        vec_t vt [2];
        logic [127:0] pt, key, exp;
        int t, b;
        logic [7:0] inv;
        vt[0] = '{128'h3243f6a8885a308d313198a2e0370734,
                  128'h2b7e151628aed2a6abf7158809cf4f3c,
                  128'h3925841d02dc09fbdc118597196a0b32};
        vt[1] = '{128'h00112233445566778899aabbccddeeff,
                  128'h000102030405060708090a0b0c0d0e0f,
                  128'h69c4e0d86a7b0430d8cdb78070b4c55a};
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                  ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
        for (int i = 0; i < 16; i++) rkB[i] = '0;
        expand128(vt[0].key);

        repeat (2) @(negedge clk);
        chk("reset flags A",
            {in_ready_A, out_valid_A, ss_en_A, mc_en_A, busy_A}, 5'b10000);
        chk("reset rk_idx A", rk_idx_A, 4'd0);
        chk("reset data A", out_data_A, 128'h0);
        chk("reset flags B", {in_ready_B, out_valid_B, busy_B}, 3'b100);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 2; i++) begin
            expand128(vt[i].key);
            run_a(vt[i].pt, vt[i].ct, (i == 0) ? 20 : 0, 1'b1,
                  (i == 0) ? "fips_b" : "fips_c1");
        end

        for (int i = 0; i < 6; i++) begin
            key = {$urandom, $urandom, $urandom, $urandom};
            pt  = {$urandom, $urandom, $urandom, $urandom};
            ss_dly = $urandom_range(4, 1);
            mc_dly = $urandom_range(4, 1);
            expand128(key);
            exp = encrypt(pt, 10, rkA);
            run_a(pt, exp, 0, 1'b0, "random");
        end

        ss_dly = 3; mc_dly = 3; spur_en = 1'b1;
        expand128(vt[0].key);
        run_a(vt[0].pt, vt[0].ct, 0, 1'b0, "slow_spur");
        spur_en = 1'b0;

        in_data = vt[0].pt; in_valid = 1'b1;
        b = mcA_p;
        @(negedge clk);
        in_valid = 1'b0;
        t = 0;
        while (mcA_p - b < 5 && t < 1000) begin @(negedge clk); t++; end
        chk("mid reset reached", busy_A, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid reset flags",
            {in_ready_A, out_valid_A, ss_en_A, mc_en_A, busy_A}, 5'b10000);
        chk("mid reset rk/data", {rk_idx_A, out_data_A}, 132'h0);
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        ss_dly = 1; mc_dly = 1;
        expand128(vt[1].key);
        run_a(vt[1].pt, vt[1].ct, 0, 1'b1, "after_reset");

`ifdef AES_ABORT_EN
        ss_dly = 3; mc_dly = 2;
        expand128(vt[0].key);
        in_data = vt[0].pt; in_valid = 1'b1;
        b = ssA_p;
        @(negedge clk);
        in_valid = 1'b0;
        t = 0;
        while (ssA_p - b < 3 && t < 1000) begin @(negedge clk); t++; end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort busy", {busy_A, in_ready_A, out_valid_A}, 3'b010);
        b = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid_A || busy_A) b = 1;
        end
        chk("abort quiet", b, 0);
        run_a(vt[0].pt, vt[0].ct, 0, 1'b0, "after_abort");
`endif

        for (int i = 0; i < 15; i++)
            rkB[i] = {$urandom, $urandom, $urandom, $urandom};
        pt  = {$urandom, $urandom, $urandom, $urandom};
        exp = encrypt(pt, 14, rkB);
        in_data = pt; in_valid_B = 1'b1;
        b = ssB_p; key = 128'(mcB_p);
        @(negedge clk);
        in_valid_B = 1'b0;
        t = 1;
        while (!out_valid_B && t < 3000) begin @(negedge clk); t++; end
        chk("nr14 ct", out_data_B, exp);
        chk("nr14 ss pulses", ssB_p - b, 14);
        chk("nr14 mc pulses", 128'(mcB_p) - key, 13);
        out_ready_B = 1'b1;
        @(negedge clk);
        out_ready_B = 1'b0;
        chk("nr14 idle", {out_valid_B, in_ready_B, busy_B}, 3'b010);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
